// File: rtl/imem_loader.sv
// Boot-time loader: packs a valid/ready byte stream MSB-first into 32-bit words,
// writes them to consecutive imem addresses and holds the CPU in reset until done.
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_wEn,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_dataIn,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] words_left;
  logic                  accept;
  logic                  start_ok;

  // Every output is a pure decode of the state, so no input reaches an output combinationally.
  assign byte_ready = (state == RECV);
  assign imem_wEn   = (state == WRITE);
  assign busy       = (state == RECV) || (state == WRITE);
  assign done       = (state == DONE);
  assign cpu_reset  = (state != DONE);

  assign accept   = byte_valid && byte_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (word_count == '0) ? DONE : RECV;
      end
      RECV: begin
        if (accept && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (words_left == ADDR_WIDTH'(1)) ? DONE : RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= 2'd0;
      words_left  <= '0;
      imem_addr   <= '0;
      imem_dataIn <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok && (word_count != '0)) begin
        words_left <= word_count;
        imem_addr  <= '0;
        byte_cnt   <= 2'd0;
      end
      if (accept) begin
        imem_dataIn <= {imem_dataIn[DATA_WIDTH-9:0], byte_in};
        byte_cnt    <= byte_cnt + 2'd1;
      end
      // The last word leaves the address on the final written location.
      if ((state == WRITE) && (words_left != ADDR_WIDTH'(1))) begin
        words_left <= words_left - ADDR_WIDTH'(1);
        imem_addr  <= imem_addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue
// that a monitor drains on every imem write pulse.
module tb_imem_loader;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] word_count;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          imem_wEn;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_dataIn;
  logic          cpu_reset;
  logic          busy;
  logic          done;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_wEn(imem_wEn), .imem_addr(imem_addr), .imem_dataIn(imem_dataIn),
    .cpu_reset(cpu_reset), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  wr_count = 0;
  int  cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every write pulse is matched against the oldest expected write.
  always @(negedge clock) begin
    if (imem_wEn === 1'b1) begin
      wr_t e;
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, none expected", imem_addr, imem_dataIn);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_dataIn !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   imem_addr, imem_dataIn, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input logic [AW-1:0] wc);
    start = 1'b1;
    word_count = wc;
    tick();
    start = 1'b0;
  endtask

  // Present a byte and hold it until the loader takes it (leaves byte_valid high).
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_in = b;
    while (byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: byte %02h never accepted, byte_ready=%b", b, byte_ready);
    end
    tick();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] s1 [8];
    int c0;
    int w0;
    int idle_bad;
    s1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    reset = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and 10 idle cycles, with a byte offered that must not be taken.
    check("rst_addr", {20'd0, imem_addr}, 32'd0);
    check("rst_data", imem_dataIn, 32'd0);
    byte_valid = 1'b1;
    byte_in = 8'h55;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({cpu_reset, busy, done, byte_ready, imem_wEn} !== 5'b10000) idle_bad++;
      tick();
    end
    byte_valid = 1'b0;
    check("idle_outputs_bad_cycles", idle_bad, 0);

    // Two words back-to-back.
    expect_wr(12'd0, 32'h12345678);
    expect_wr(12'd1, 32'h9ABCDEF0);
    w0 = wr_count;
    pulse_start(12'd2);
    c0 = cyc;
    check("start_to_ready", {31'd0, byte_ready}, 32'd1);
    for (int i = 0; i < 8; i++) send_byte(s1[i]);
    byte_valid = 1'b0;
    check("last_write_cycle_wen", {31'd0, imem_wEn}, 32'd1);
    check("last_write_cycle_done", {31'd0, done}, 32'd0);
    tick();
    check("done_after_write", {31'd0, done}, 32'd1);
    check("cpu_released", {31'd0, cpu_reset}, 32'd0);
    check("cycles_start_to_done", cyc - c0, 32'd10);
    check("two_words_writes", wr_count - w0, 32'd2);
    check("done_addr_last", {20'd0, imem_addr}, 32'd1);
    check("done_ready_low", {31'd0, byte_ready}, 32'd0);

    // One word with byte_valid toggling every cycle.
    expect_wr(12'd0, 32'hAABBCCDD);
    pulse_start(12'd1);
    check("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    foreach (s1[i]) s1[i] = 8'h00;
    s1[0] = 8'hAA; s1[1] = 8'hBB; s1[2] = 8'hCC; s1[3] = 8'hDD;
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b0;
      byte_in = 8'hEE;
      tick();
      send_byte(s1[i]);
    end
    byte_valid = 1'b0;
    wait_done("toggle_done");

    // Zero-word load.
    w0 = wr_count;
    pulse_start(12'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);
    tick();
    check("zero_no_write", wr_count - w0, 32'd0);

    // Reset in the middle of a three-word load.
    expect_wr(12'd0, 32'h01020304);
    w0 = wr_count;
    pulse_start(12'd3);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    byte_valid = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    word_count = 12'd5;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    check("midrst_idle_stays", {31'd0, busy}, 32'd0);
    check("midrst_writes", wr_count - w0, 32'd1);
    expect_wr(12'd0, 32'hCAFEF00D);
    pulse_start(12'd1);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    byte_valid = 1'b0;
    wait_done("reload_done");

    // Start from DONE, then a start mid-load that must be ignored.
    expect_wr(12'd0, 32'h11223344);
    expect_wr(12'd1, 32'h55667788);
    w0 = wr_count;
    pulse_start(12'd2);
    check("done_restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("done_restart_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h11); send_byte(8'h22);
    byte_valid = 1'b0;
    pulse_start(12'd5);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    byte_valid = 1'b0;
    wait_done("ignored_start_done");
    check("ignored_start_writes", wr_count - w0, 32'd2);
    check("ignored_start_addr", {20'd0, imem_addr}, 32'd1);

    // Extra byte after completion is never consumed.
    byte_valid = 1'b1;
    byte_in = 8'h99;
    tick();
    tick();
    check("extra_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("extra_byte_data", imem_dataIn, 32'h55667788);
    byte_valid = 1'b0;
    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
